// File: rtl/rv_decode_pkg.sv
// Shared types and the RV32I/M decode function for the registered decode stage.
// The bundle struct carries only XLEN-independent fields; pc/imm live beside it.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASS_B = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_lui;
        logic       is_auipc;
        logic       writes_rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       illegal;
    } dec_t;

    // funct3 -> ALU op for the funct7==0 register/immediate arithmetic group
    function automatic alu_op_e alu_base(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] ins, input logic support_m,
                                    output imm_fmt_e fmt);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3       = ins[14:12];
        f7       = ins[31:25];
        d        = '0;
        fmt      = IMM_NONE;
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.funct3 = f3;
        d.alu_op = ALU_ADD;
        case (ins[6:0])
            OPC_LOAD: begin
                fmt         = IMM_I;
                d.is_load   = 1'b1;
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
                d.illegal   = (f3 == 3'd3) || (f3 > 3'd5);
            end
            OPC_STORE: begin
                fmt        = IMM_S;
                d.is_store = 1'b1;
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
                d.illegal  = (f3 > 3'd2);
            end
            OPC_OP_IMM: begin
                fmt         = IMM_I;
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
                d.alu_op    = alu_base(f3);
                if (f3 == 3'd1) begin
                    d.illegal = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h20) d.alu_op = ALU_SRA;
                    else             d.illegal = (f7 != 7'h00);
                end
            end
            OPC_OP: begin
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                if (f7 == 7'h00) begin
                    d.alu_op = alu_base(f3);
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    d.alu_op = ALU_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    d.alu_op = ALU_SRA;
                end else if (f7 == 7'h01 && support_m) begin
                    d.alu_op = alu_op_e'({2'b10, f3});
                end else begin
                    d.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                fmt         = IMM_U;
                d.alu_op    = ALU_PASS_B;
                d.is_lui    = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                fmt         = IMM_U;
                d.is_auipc  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                fmt         = IMM_B;
                d.alu_op    = ALU_SUB;
                d.is_branch = 1'b1;
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.illegal   = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_JALR: begin
                fmt         = IMM_I;
                d.is_jalr   = 1'b1;
                d.writes_rd = 1'b1;
                d.uses_rs1  = 1'b1;
                d.illegal   = (f3 != 3'd0);
            end
            OPC_JAL: begin
                fmt         = IMM_J;
                d.is_jal    = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPC_MISC_MEM: ;
            default: d.illegal = 1'b1;
        endcase
        // An illegal word still travels down the pipe but must have no side effects
        if (d.illegal) begin
            fmt         = IMM_NONE;
            d.alu_op    = ALU_ADD;
            d.is_load   = 1'b0;
            d.is_store  = 1'b0;
            d.is_branch = 1'b0;
            d.is_jal    = 1'b0;
            d.is_jalr   = 1'b0;
            d.is_lui    = 1'b0;
            d.is_auipc  = 1'b0;
            d.writes_rd = 1'b0;
            d.uses_rs1  = 1'b0;
            d.uses_rs2  = 1'b0;
        end
        if (d.rd == 5'd0) d.writes_rd = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate extraction for the RISC-V I/S/B/U/J formats, sign-extended to XLEN.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm32 = {instr_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Every format already has its sign in bit 31, so widening is a plain replicate
    generate
        if (XLEN > 32) begin : g_wide
            assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm_o = imm32[XLEN-1:0];
        end
    endgenerate

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I(M) decode stage: decodes on the input side, then holds bundles
// in an output register backed by one skid register toward execute.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SUPPORT_M = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [XLEN-1:0]  dec_pc,
    output logic [4:0]       alu_op,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [XLEN-1:0]  imm,
    output logic             is_load,
    output logic             is_store,
    output logic             is_branch,
    output logic             is_jal,
    output logic             is_jalr,
    output logic             is_lui,
    output logic             is_auipc,
    output logic             writes_rd,
    output logic             uses_rs1,
    output logic             uses_rs2,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef struct packed {
        logic            valid;
        dec_t            dec;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t           out_q, out_d;
    entry_t           skid_q, skid_d;
    entry_t           new_e;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dec_t             new_dec;
    imm_fmt_e         new_fmt;
    logic [XLEN-1:0]  new_imm;
    logic             accept;
    logic             handoff;

    always_comb begin
        new_fmt = IMM_NONE;
        new_dec = decode(instr, SUPPORT_M != 0, new_fmt);
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (instr),
        .fmt_i   (new_fmt),
        .imm_o   (new_imm)
    );

    assign accept  = instr_valid && ready_q;
    assign handoff = out_q.valid && dec_ready;

    always_comb begin
        new_e.valid = 1'b1;
        new_e.dec   = new_dec;
        new_e.pc    = pc;
        new_e.imm   = new_imm;

        out_d  = out_q;
        skid_d = skid_q;
        if (flush) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!out_q.valid || handoff) begin
            // SKID holds the older word, so it refills OUT before anything new
            if (skid_q.valid) begin
                out_d = skid_q;
                if (accept) skid_d       = new_e;
                else        skid_d.valid = 1'b0;
            end else if (accept) begin
                out_d = new_e;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            skid_d = new_e;
        end

        ready_d = !skid_d.valid;

        cnt_d = cnt_q;
        if (handoff && out_q.dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_ready   = ready_q;
    assign dec_valid     = out_q.valid;
    assign dec_pc        = out_q.pc;
    assign imm           = out_q.imm;
    assign alu_op        = out_q.dec.alu_op;
    assign rd            = out_q.dec.rd;
    assign rs1           = out_q.dec.rs1;
    assign rs2           = out_q.dec.rs2;
    assign funct3        = out_q.dec.funct3;
    assign is_load       = out_q.dec.is_load;
    assign is_store      = out_q.dec.is_store;
    assign is_branch     = out_q.dec.is_branch;
    assign is_jal        = out_q.dec.is_jal;
    assign is_jalr       = out_q.dec.is_jalr;
    assign is_lui        = out_q.dec.is_lui;
    assign is_auipc      = out_q.dec.is_auipc;
    assign writes_rd     = out_q.dec.writes_rd;
    assign uses_rs1      = out_q.dec.uses_rs1;
    assign uses_rs2      = out_q.dec.uses_rs2;
    assign illegal       = out_q.dec.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench: a 32-bit/no-M instance and a 64-bit/M instance share one
// stimulus bus; sel picks which one is driven and observed.
module tb_rv_decode_stage;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] w;
        logic [4:0]  alu;
        logic [63:0] imm;
        logic        ci;
        logic [6:0]  cls;
        logic        wr;
        logic        u1;
        logic        u2;
        logic        ill;
    } exp_t;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LOAD  = 7'b1000000;
    localparam logic [6:0] C_STORE = 7'b0100000;
    localparam logic [6:0] C_BR    = 7'b0010000;
    localparam logic [6:0] C_JAL   = 7'b0001000;
    localparam logic [6:0] C_JALR  = 7'b0000100;
    localparam logic [6:0] C_LUI   = 7'b0000010;
    localparam logic [6:0] C_AUIPC = 7'b0000001;
    localparam logic [31:0] ECALL  = 32'h0000_0073;

    logic        clk = 1'b0;
    logic        rst_n, flush, instr_valid, dec_ready, sel;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        a_iready, a_valid, a_ld, a_st, a_br, a_jal, a_jalr, a_lui, a_auipc;
    logic        a_wr, a_u1, a_u2, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_alu, a_rd, a_rs1, a_rs2;
    logic [2:0]  a_f3;
    logic [15:0] a_cnt;

    logic        b_iready, b_valid, b_ld, b_st, b_br, b_jal, b_jalr, b_lui, b_auipc;
    logic        b_wr, b_u1, b_u2, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_alu, b_rd, b_rs1, b_rs2;
    logic [2:0]  b_f3;
    logic [3:0]  b_cnt;

    logic        o_ready, o_valid, o_wr, o_u1, o_u2, o_ill;
    logic [63:0] o_pc, o_imm;
    logic [4:0]  o_alu, o_rd, o_rs1, o_rs2;
    logic [2:0]  o_f3;
    logic [6:0]  o_cls;
    logic [15:0] o_cnt;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [63:0] pc_ctr;
    exp_t        idle_e;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .SUPPORT_M(0), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid && !sel), .instr_ready(a_iready),
        .instr(instr), .pc(pc[31:0]),
        .dec_valid(a_valid), .dec_ready(dec_ready), .dec_pc(a_pc),
        .alu_op(a_alu), .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .funct3(a_f3), .imm(a_imm),
        .is_load(a_ld), .is_store(a_st), .is_branch(a_br), .is_jal(a_jal),
        .is_jalr(a_jalr), .is_lui(a_lui), .is_auipc(a_auipc),
        .writes_rd(a_wr), .uses_rs1(a_u1), .uses_rs2(a_u2), .illegal(a_ill),
        .illegal_count(a_cnt)
    );

    rv_decode_stage #(.XLEN(64), .SUPPORT_M(1), .CNT_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .instr_valid(instr_valid && sel), .instr_ready(b_iready),
        .instr(instr), .pc(pc),
        .dec_valid(b_valid), .dec_ready(dec_ready), .dec_pc(b_pc),
        .alu_op(b_alu), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .funct3(b_f3), .imm(b_imm),
        .is_load(b_ld), .is_store(b_st), .is_branch(b_br), .is_jal(b_jal),
        .is_jalr(b_jalr), .is_lui(b_lui), .is_auipc(b_auipc),
        .writes_rd(b_wr), .uses_rs1(b_u1), .uses_rs2(b_u2), .illegal(b_ill),
        .illegal_count(b_cnt)
    );

    always_comb begin
        if (sel) begin
            o_ready = b_iready; o_valid = b_valid; o_pc = b_pc; o_imm = b_imm;
            o_alu = b_alu; o_rd = b_rd; o_rs1 = b_rs1; o_rs2 = b_rs2; o_f3 = b_f3;
            o_cls = {b_ld, b_st, b_br, b_jal, b_jalr, b_lui, b_auipc};
            o_wr = b_wr; o_u1 = b_u1; o_u2 = b_u2; o_ill = b_ill; o_cnt = {12'b0, b_cnt};
        end else begin
            o_ready = a_iready; o_valid = a_valid; o_pc = {32'b0, a_pc};
            o_imm = {{32{a_imm[31]}}, a_imm};
            o_alu = a_alu; o_rd = a_rd; o_rs1 = a_rs1; o_rs2 = a_rs2; o_f3 = a_f3;
            o_cls = {a_ld, a_st, a_br, a_jal, a_jalr, a_lui, a_auipc};
            o_wr = a_wr; o_u1 = a_u1; o_u2 = a_u2; o_ill = a_ill; o_cnt = a_cnt;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (q.size() == 0) begin
            chk("unexpected_bundle", {32'b0, instr}, 64'hDEAD);
        end else begin
            e = q.pop_front();
            $display("handoff pc=%0h word=%h rd=%0d alu=%0d illegal=%0b", o_pc, e.w, o_rd, o_alu, o_ill);
            chk("pc", o_pc, e.pc);
            chk("illegal", {63'b0, o_ill}, {63'b0, e.ill});
            chk("writes_rd", {63'b0, o_wr}, {63'b0, e.wr});
            chk("class", {57'b0, o_cls}, {57'b0, e.cls});
            chk("rd", {59'b0, o_rd}, {59'b0, e.w[11:7]});
            chk("rs1", {59'b0, o_rs1}, {59'b0, e.w[19:15]});
            chk("rs2", {59'b0, o_rs2}, {59'b0, e.w[24:20]});
            chk("funct3", {61'b0, o_f3}, {61'b0, e.w[14:12]});
            if (!e.ill) begin
                chk("alu_op", {59'b0, o_alu}, {59'b0, e.alu});
                chk("uses_rs1", {63'b0, o_u1}, {63'b0, e.u1});
                chk("uses_rs2", {63'b0, o_u2}, {63'b0, e.u2});
                if (e.ci) chk("imm", o_imm, e.imm);
            end
        end
    endtask

    // One cycle: drive at negedge, score handoff/accept, advance to next negedge
    task automatic step(input logic v, input exp_t e);
        instr_valid = v;
        instr       = e.w;
        pc          = e.pc;
        if (o_valid && dec_ready) compare_pop();
        if (v && o_ready && !flush) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input logic [4:0] alu, input logic [63:0] imm,
                        input logic ci, input logic [6:0] cls, input logic wr,
                        input logic u1, input logic u2, input logic ill);
        exp_t e;
        e.pc = pc_ctr; e.w = w; e.alu = alu; e.imm = imm; e.ci = ci; e.cls = cls;
        e.wr = wr; e.u1 = u1; e.u2 = u2; e.ill = ill;
        pc_ctr = pc_ctr + 64'd4;
        step(1'b1, e);
    endtask

    task automatic send_ill(input logic [31:0] w);
        send(w, 5'd0, 64'd0, 1'b0, C_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        dec_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, idle_e);
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("idle_valid", {63'b0, o_valid}, 64'd0);
    endtask

    initial begin
        idle_e = '{pc: 64'd0, w: 32'd0, alu: 5'd0, imm: 64'd0, ci: 1'b0, cls: 7'd0,
                   wr: 1'b0, u1: 1'b0, u2: 1'b0, ill: 1'b0};
        rst_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0; sel = 1'b0;
        instr = 32'd0; pc = 64'd0; pc_ctr = 64'h8000_0000;

        repeat (2) @(negedge clk);
        chk("rst_ready", {63'b0, o_ready}, 64'd0);
        chk("rst_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_cnt", {48'b0, o_cnt}, 64'd0);
        chk("rst_imm", o_imm, 64'd0);
        chk("rst_rd", {59'b0, o_rd}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_rst", {63'b0, o_ready}, 64'd1);

        // latency: accepted word is visible one cycle later
        dec_ready = 1'b1;
        send(32'hFFF1_0093, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lat_valid", {63'b0, o_valid}, 64'd1);
        drain();

        // back-to-back mix with dec_ready high
        send(32'hFE00_0EE3, 5'd1,  64'hFFFF_FFFF_FFFF_FFFC, 1'b1, C_BR,    1'b0, 1'b1, 1'b1, 1'b0);
        send(32'h1234_50B7, 5'd10, 64'h0000_0000_1234_5000, 1'b1, C_LUI,   1'b1, 1'b0, 1'b0, 1'b0);
        send_ill(32'h0220_8033);
        send(32'h0FF0_000F, 5'd0,  64'd0,                   1'b0, C_NONE,  1'b0, 1'b0, 1'b0, 1'b0);
        send(32'h0083_2283, 5'd0,  64'd8,                   1'b1, C_LOAD,  1'b1, 1'b1, 1'b0, 1'b0);
        send(32'hFE73_2C23, 5'd0,  64'hFFFF_FFFF_FFFF_FFF8, 1'b1, C_STORE, 1'b0, 1'b1, 1'b1, 1'b0);
        send(32'h0010_00EF, 5'd0,  64'h800,                 1'b1, C_JAL,   1'b1, 1'b0, 1'b0, 1'b0);
        send(32'hFF9F_F06F, 5'd0,  64'hFFFF_FFFF_FFFF_FFF8, 1'b1, C_JAL,   1'b0, 1'b0, 1'b0, 1'b0);
        send(32'h0042_80E7, 5'd0,  64'd4,                   1'b1, C_JALR,  1'b1, 1'b1, 1'b0, 1'b0);
        send_ill(32'h0042_90E7);
        send(32'h4020_81B3, 5'd1,  64'd0,                   1'b0, C_NONE,  1'b1, 1'b1, 1'b1, 1'b0);
        send(32'h4020_D1B3, 5'd7,  64'd0,                   1'b0, C_NONE,  1'b1, 1'b1, 1'b1, 1'b0);
        send_ill(32'h4020_E1B3);
        send(32'h4032_D213, 5'd7,  64'h403,                 1'b1, C_NONE,  1'b1, 1'b1, 1'b0, 1'b0);
        send_ill(32'h4032_9213);
        send_ill(ECALL);
        send_ill(32'h0000_0000);
        send_ill(32'h0083_3283);
        send_ill(32'hFE00_2EE3);
        send(32'hFFFF_F517, 5'd0,  64'hFFFF_FFFF_FFFF_F000, 1'b1, C_AUIPC, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();
        chk("cnt32_after_mix", {48'b0, o_cnt}, 64'd8);

        // backpressure: third back-to-back word is refused
        dec_ready = 1'b0;
        chk("bp_ready1", {63'b0, o_ready}, 64'd1);
        send(32'h0010_0113, 5'd0, 64'd1, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_ready2", {63'b0, o_ready}, 64'd1);
        send(32'h0020_0193, 5'd0, 64'd2, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_ready3", {63'b0, o_ready}, 64'd0);
        send(32'h0030_0213, 5'd0, 64'd3, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_ready4", {63'b0, o_ready}, 64'd0);
        chk("bp_hold_rd", {59'b0, o_rd}, 64'd2);
        chk("bp_queue", 64'(q.size()), 64'd2);
        drain();

        // random dec_ready exercises skid ordering
        for (int i = 1; i <= 12; i++) begin
            logic [31:0] w;
            w = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
            dec_ready = 1'($urandom_range(0, 1));
            send(w, 5'd0, 64'(i), 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        drain();

        // flush with OUT and SKID full plus a new word on the bus
        dec_ready = 1'b0;
        send(32'h0010_0113, 5'd0, 64'd1, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        send(32'h0020_0193, 5'd0, 64'd2, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        send(32'h0030_0213, 5'd0, 64'd3, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        flush = 1'b0;
        q.delete();
        chk("flush_valid", {63'b0, o_valid}, 64'd0);
        chk("flush_ready", {63'b0, o_ready}, 64'd1);
        dec_ready = 1'b1;
        step(1'b0, idle_e);
        chk("flush_idle", {63'b0, o_valid}, 64'd0);

        // flush drops an illegal in OUT and a word accepted in the same cycle
        dec_ready = 1'b0;
        send_ill(ECALL);
        flush = 1'b1;
        send(32'h0040_0293, 5'd0, 64'd4, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        flush = 1'b0;
        q.delete();
        dec_ready = 1'b1;
        chk("flush2_valid", {63'b0, o_valid}, 64'd0);
        step(1'b0, idle_e);
        chk("flush2_cnt", {48'b0, o_cnt}, 64'd8);
        send(32'h0050_0313, 5'd0, 64'd5, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // 64-bit, M-enabled instance
        sel = 1'b1;
        pc_ctr = 64'h0000_0001_0000_1000;
        dec_ready = 1'b1;
        step(1'b0, idle_e);
        send(32'hFFF1_0093, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, C_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        send(32'hFFFF_F0B7, 5'd10, 64'hFFFF_FFFF_FFFF_F000, 1'b1, C_LUI,  1'b1, 1'b0, 1'b0, 1'b0);
        send(32'h0220_8033, 5'd16, 64'd0,                   1'b0, C_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
        send(32'h0273_62B3, 5'd22, 64'd0,                   1'b0, C_NONE, 1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        chk("cnt64_legal", {48'b0, o_cnt}, 64'd0);
        for (int i = 0; i < 15; i++) send_ill(ECALL);
        drain();
        chk("cnt64_at_max", {48'b0, o_cnt}, 64'd15);
        send_ill(ECALL);
        send_ill(ECALL);
        drain();
        chk("cnt64_saturated", {48'b0, o_cnt}, 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
